// File: rtl/instr_loader_if.sv
// rtl/instr_loader_if.sv - load stream and fetch stream bundle for instr_loader
interface instr_loader_if #(
    parameter int IW = 25,
    parameter int AW = 6
);
    logic          load_valid;
    logic          load_ready;
    logic [IW-1:0] load_data;
    logic          load_last;
    logic          fetch_en;
    logic [IW-1:0] instructionOut;
    logic          fetch_valid;
    logic          done;
    logic [AW:0]   count;

    modport master (
        output load_valid, load_data, load_last, fetch_en,
        input  load_ready, instructionOut, fetch_valid, done, count
    );

    modport slave (
        input  load_valid, load_data, load_last, fetch_en,
        output load_ready, instructionOut, fetch_valid, done, count
    );
endinterface

// File: rtl/instr_loader.sv
// rtl/instr_loader.sv - buffers a streamed program, then replays it as a registered fetch stream
// Optional INSTR_LOADER_LOOP_EN: replay the program forever instead of ending in DONE.
module instr_loader #(
    parameter int IW    = 25,
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic           clk,
    input  logic           reset,
    instr_loader_if.slave  lb
);
    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE_C   = (AW+1)'(1);

    state_t        state_q, state_d;
    logic [AW:0]   count_q, count_d;
    logic [AW:0]   pc_q, pc_d;
    logic [IW-1:0] instr_q, instr_d;
    logic          fetch_valid_q, fetch_valid_d;
    logic          wr_en;
    logic          load_ready;

    logic [IW-1:0] mem [DEPTH];

    assign load_ready = (state_q == ST_LOAD) && (count_q < DEPTH_C);

    always_comb begin
        state_d       = state_q;
        count_d       = count_q;
        pc_d          = pc_q;
        instr_d       = instr_q;
        fetch_valid_d = 1'b0;
        wr_en         = 1'b0;
        case (state_q)
            ST_LOAD: begin
                if (lb.load_valid && load_ready) begin
                    wr_en   = 1'b1;
                    count_d = count_q + ONE_C;
                    if (lb.load_last || (count_d == DEPTH_C)) begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (lb.fetch_en) begin
                    instr_d       = mem[pc_q[AW-1:0]];
                    fetch_valid_d = 1'b1;
                    pc_d          = pc_q + ONE_C;
                    // Last word of the program is being issued this cycle
                    if (pc_q == (count_q - ONE_C)) begin
`ifdef INSTR_LOADER_LOOP_EN
                        pc_d = '0;
`else
                        state_d = ST_DONE;
`endif
                    end
                end
            end
            ST_DONE: begin
                instr_d = '0;
            end
            default: begin
                state_d = ST_LOAD;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_LOAD;
            count_q       <= '0;
            pc_q          <= '0;
            instr_q       <= '0;
            fetch_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            count_q       <= count_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            fetch_valid_q <= fetch_valid_d;
        end
    end

    // Buffer is intentionally not reset; every entry read is written first
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[count_q[AW-1:0]] <= lb.load_data;
        end
    end

    assign lb.load_ready     = load_ready;
    assign lb.instructionOut = instr_q;
    assign lb.fetch_valid    = fetch_valid_q;
    assign lb.done           = (state_q == ST_DONE);
    assign lb.count          = count_q;
endmodule

// File: tb/tb_instr_loader.sv
// tb/tb_instr_loader.sv - directed and randomized bench for instr_loader against a queue-based program model
module tb_instr_loader;
    localparam int IW    = 25;
    localparam int DEPTH = 64;
    localparam int AW    = 6;

    logic clk;
    logic reset_n;
    int   vectors;
    int   errs;

    instr_loader_if #(.IW(IW), .AW(AW)) bus ();

    instr_loader #(.IW(IW), .DEPTH(DEPTH), .AW(AW)) dut (
        .clk   (clk),
        .reset (reset_n),
        .lb    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Program model: the accepted words in order, plus replay position
    logic [IW-1:0] prog [$];
    bit            m_loaded;
    bit            m_done;
    int            fi;
    logic [IW-1:0] m_instr;
    bit            m_fv;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        chk("fetch_valid", 32'(bus.fetch_valid), 32'(m_fv));
        chk("instr",       32'(bus.instructionOut), 32'(m_instr));
        chk("done",        32'(bus.done), 32'(m_done));
        chk("count",       32'(bus.count), 32'(prog.size()));
        chk("load_ready",  32'(bus.load_ready), 32'(!m_loaded));
    endtask

    task automatic model_clear();
        prog.delete();
        m_loaded = 0;
        m_done   = 0;
        fi       = 0;
        m_instr  = '0;
        m_fv     = 0;
    endtask

    // One clock: apply inputs, advance the model, check every output after the edge
    task automatic step(input bit lv, input logic [IW-1:0] ld, input bit ll, input bit fe);
        bus.load_valid = lv;
        bus.load_data  = ld;
        bus.load_last  = ll;
        bus.fetch_en   = fe;
        @(posedge clk);
        if (!m_loaded) begin
            m_fv = 0;
            if (lv) begin
                prog.push_back(ld);
                if (ll || prog.size() == DEPTH) m_loaded = 1;
            end
        end else if (m_done) begin
            m_instr = '0;
            m_fv    = 0;
        end else if (fe) begin
            m_instr = prog[fi];
            m_fv    = 1;
            fi++;
            if (fi == prog.size()) begin
`ifdef INSTR_LOADER_LOOP_EN
                fi = 0;
`else
                m_done = 1;
`endif
            end
        end else begin
            m_fv = 0;
        end
        #1;
        check_outputs();
    endtask

    task automatic apply_reset();
        #2;
        reset_n = 1'b0;
        #1;
        model_clear();
        chk("rst_instr",       32'(bus.instructionOut), 32'h0);
        chk("rst_fetch_valid", 32'(bus.fetch_valid), 32'h0);
        chk("rst_count",       32'(bus.count), 32'h0);
        chk("rst_done",        32'(bus.done), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("rst_load_ready",  32'(bus.load_ready), 32'h1);
    endtask

    task automatic random_round();
        int n;
        int cyc;
        bit lv;
        bit ll;
        n = $urandom_range(1, DEPTH);
        cyc = 0;
        apply_reset();
        while (!m_loaded && cyc < 600) begin
            lv = ($urandom_range(0, 3) != 0);
            ll = lv ? (prog.size() == n - 1) : 1'($urandom_range(0, 1));
            step(lv, IW'($urandom), ll, 1'($urandom_range(0, 1)));
            cyc++;
        end
        chk("load_bound", 32'(m_loaded), 32'h1);
        for (int i = 0; i < n + 30; i++) begin
            step(1'($urandom_range(0, 1)), IW'($urandom), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 3) != 0));
        end
    endtask

    logic [IW-1:0] w3 [3];
    bit            bp_valid [6];

    initial begin
        vectors = 0;
        errs    = 0;
        reset_n = 1'b0;
        bus.load_valid = 1'b0;
        bus.load_data  = '0;
        bus.load_last  = 1'b0;
        bus.fetch_en   = 1'b0;
        model_clear();
        #12;
        check_outputs();
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check_outputs();

        // Three-word program, continuous fetch
        w3[0] = 25'h0000001;
        w3[1] = 25'h0ABCDEF;
        w3[2] = 25'h1FFFFFF;
        for (int i = 0; i < 3; i++) step(1'b1, w3[i], (i == 2), 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b0, 1'b1);

        // Full buffer without load_last, then an ignored 65th word
        apply_reset();
        for (int i = 0; i < DEPTH; i++) step(1'b1, IW'(i), 1'b0, 1'b1);
        step(1'b1, 25'h1234567, 1'b0, 1'b0);
        for (int i = 0; i < DEPTH + 3; i++) step(1'b1, IW'($urandom), 1'b0, 1'b1);

        // Gapped load_valid, stray load_last on an idle cycle
        apply_reset();
        bp_valid = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 6; i++) step(bp_valid[i], IW'($urandom), (i == 1) || (i == 5), 1'b1);
        for (int i = 0; i < 7; i++) step(1'b0, '0, 1'b0, 1'b1);

        // Stall for three cycles after the second fetch
        apply_reset();
        for (int i = 0; i < 5; i++) step(1'b1, IW'($urandom), (i == 4), 1'b0);
        step(1'b0, '0, 1'b0, 1'b1);
        step(1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b0, 1'b1);

        // Reset partway through the run, then a one-word reload
        apply_reset();
        for (int i = 0; i < 5; i++) step(1'b1, IW'($urandom), (i == 4), 1'b0);
        step(1'b0, '0, 1'b0, 1'b1);
        step(1'b0, '0, 1'b0, 1'b1);
        apply_reset();
        step(1'b1, 25'h15A5A5A, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b0, 1'b1);

        for (int r = 0; r < 12; r++) random_round();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule

// File: doc/instr_loader.md
Name: instr_loader

Overview:
- Writer-side counterpart to the pipeline's instruction fetch stage.
- Accepts a program as a valid/ready stream of 25-bit instruction words and stores it in an internal instruction buffer.
- Once loading completes, it replays the buffer in order as a registered fetch stream that feeds the IF/ID register.
- Sits between the testbench/host loader and the pipeline front end, so IF no longer needs a hard-coded program.

Parameters:
- IW, 25, instruction word width
- DEPTH, 64, instruction buffer entries
- AW, 6, address width (log2 DEPTH)

Ports:
- clk  input  1  system clock; all state on posedge
- reset  input  1  asynchronous, active-low reset
- load_valid  input  1  load_data holds a valid instruction word
- load_ready  output  1  block can accept a word this cycle
- load_data  input  IW  instruction word to store
- load_last  input  1  qualifies the final word of the program (sampled with load_valid)
- fetch_en  input  1  pipeline requests the next instruction (low = stall)
- instructionOut  output  IW  fetched instruction, registered
- fetch_valid  output  1  instructionOut updated this cycle
- done  output  1  program fully fetched
- count  output  AW+1  number of words loaded (0..DEPTH)

Behaviour:
- Reset (reset=0, async):
  - state=LOAD, count=0, pc=0, instructionOut=0, fetch_valid=0, done=0, load_ready=1 after reset release.
  - Buffer contents are not cleared and are don't-care.
- States: LOAD -> RUN -> DONE. There is no path back to LOAD except reset.
- LOAD:
  - load_ready = 1 while count < DEPTH.
  - On load_valid & load_ready: mem[count[AW-1:0]] <= load_data; count <= count+1.
  - Transition to RUN on the same edge as the accepted word if load_last=1 or count+1 == DEPTH.
  - load_valid while load_ready=0 is ignored; no write, count holds.
  - load_last without load_valid is ignored.
- RUN:
  - load_ready = 0.
  - On fetch_en=1: instructionOut <= mem[pc]; fetch_valid <= 1; pc <= pc+1.
  - On fetch_en=0: instructionOut holds; fetch_valid <= 0; pc holds.
  - Latency: fetch_en sampled at edge N produces instructionOut/fetch_valid valid after edge N.
  - When the fetch at pc == count-1 is issued, state -> DONE on the same edge.
- DONE:
  - done=1, fetch_valid=0.
  - instructionOut <= 0 (all-zero word) on the first edge in DONE, then holds.
  - fetch_en and load_* are ignored.
- pc width is AW+1 so pc == DEPTH is representable; no wrap in base configuration.
- fetch_en asserted during LOAD is ignored; fetch_valid stays 0.
- Reset asserted mid-LOAD or mid-RUN aborts immediately: all outputs return to reset values, and the program must be reloaded.
- count holds its final value through RUN and DONE.

Optional Feature:
- Macro: INSTR_LOADER_LOOP_EN.
- Defined:
  - In RUN, the fetch at pc == count-1 sets pc <= 0 and stays in RUN, replaying the program indefinitely.
  - DONE is unreachable; done stays 0.
- Undefined: behaviour exactly as above (single pass, terminating in DONE).

Test Plan:
- Load 3 words 25'h0000001, 25'h0ABCDEF, 25'h1FFFFFF (last on 3rd), then fetch_en=1 continuously -> count=3; instructionOut = 0000001, 0ABCDEF, 1FFFFFF on consecutive cycles with fetch_valid=1; next cycle done=1, fetch_valid=0, instructionOut=0.
- Load 64 words with value = index, load_last never asserted -> load_ready drops after the 64th accept; a 65th load_valid is ignored; count=64; fetch yields 0..63 in order, then done.
- Backpressure: load_valid toggles 1,0,1,1,0,1 with last on the 4th valid word -> exactly 4 words stored in order; count=4.
- Stall: during RUN, hold fetch_en=0 for 3 cycles after the 2nd fetch -> fetch_valid=0 and instructionOut holds the 2nd word for 3 cycles; the 3rd word appears one cycle after fetch_en returns high.
- Reset mid-RUN after 2 of 5 fetches -> immediate return to LOAD: count=0, instructionOut=0, fetch_valid=0, load_ready=1 after release; reloading 1 word and fetching returns that word.
- With INSTR_LOADER_LOOP_EN: load 2 words A,B; fetch_en=1 for 6 cycles -> A,B,A,B,A,B; done stays 0.
